// File: rtl/vga_img_pkg.sv
// rtl/vga_img_pkg.sv - shared image geometry, pixel constants, owner/state enums and return tag
// Purpose: common definitions for the image BRAM arbiter and its read-return pipeline.
// Contents: IMG_W/IMG_H/IMG_PIXELS geometry, ADDR_W/PIX_W widths, OOB_PIXEL fill byte,
//           owner_e (who issued a read), arb_state_e (arbiter FSM), rd_tag_t (return tag).
package vga_img_pkg;
    localparam int IMG_W      = 160;
    localparam int IMG_H      = 120;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int ADDR_W     = 15;
    localparam int PIX_W      = 8;

    localparam logic [PIX_W-1:0] OOB_PIXEL = 8'hFF;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_AES  = 1'b1
    } owner_e;

    typedef enum logic {
        ARB      = 1'b0,
        AES_LOCK = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
        logic   oob;
    } rd_tag_t;
endpackage

// File: rtl/vga_img_mem_arbiter_tag_pipe.sv
// rtl/vga_img_mem_arbiter_tag_pipe.sv - read-return tag pipeline routing BRAM data to its requester
// Module img_rd_tag_pipe: RD_LAT+1 deep shift register of {valid, owner, oob} tags.
// Ports:
//   clk, rst              clock, asynchronous active-high reset (clears all tags and outputs)
//   in_valid/in_aes/in_oob tag of the read granted this cycle (in_aes: 1 = AES owns it)
//   mem_rdata             BRAM read data, valid RD_LAT cycles after mem_en
//   disp_rvalid/disp_rdata display return pulse and held byte
//   aes_rvalid/aes_rdata   AES return pulse and held byte
module img_rd_tag_pipe
    import vga_img_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_aes,
    input  logic       in_oob,
    input  logic [7:0] mem_rdata,
    output logic       disp_rvalid,
    output logic [7:0] disp_rdata,
    output logic       aes_rvalid,
    output logic [7:0] aes_rdata
);
    // Stage 0 lines up with the registered mem_en; stage RD_LAT lines up with mem_rdata.
    rd_tag_t [RD_LAT:0] tag_q, tag_d;
    rd_tag_t            ret;
    logic [7:0]         ret_data;
    logic               disp_rvalid_q, disp_rvalid_d;
    logic               aes_rvalid_q, aes_rvalid_d;
    logic [7:0]         disp_rdata_q, disp_rdata_d;
    logic [7:0]         aes_rdata_q, aes_rdata_d;

    always_comb begin
        tag_d[0] = '{valid: in_valid, owner: (in_aes ? OWN_AES : OWN_DISP), oob: in_oob};
        for (int i = 1; i <= RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        ret           = tag_q[RD_LAT];
        // Out-of-range reads never enabled the BRAM, so substitute the fill byte.
        ret_data      = ret.oob ? OOB_PIXEL : mem_rdata;
        disp_rvalid_d = ret.valid && (ret.owner == OWN_DISP);
        aes_rvalid_d  = ret.valid && (ret.owner == OWN_AES);
        disp_rdata_d  = disp_rvalid_d ? ret_data : disp_rdata_q;
        aes_rdata_d   = aes_rvalid_d ? ret_data : aes_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q         <= '0;
            disp_rvalid_q <= 1'b0;
            aes_rvalid_q  <= 1'b0;
            disp_rdata_q  <= 8'd0;
            aes_rdata_q   <= 8'd0;
        end else begin
            tag_q         <= tag_d;
            disp_rvalid_q <= disp_rvalid_d;
            aes_rvalid_q  <= aes_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            aes_rdata_q   <= aes_rdata_d;
        end
    end

    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign aes_rvalid  = aes_rvalid_q;
    assign aes_rdata   = aes_rdata_q;
endmodule

// File: rtl/vga_img_mem_arbiter.sv
// rtl/vga_img_mem_arbiter.sv - image BRAM arbiter between VGA pixel fetch and AES engine
// Display reads win by default; AES takes idle slots and bounded atomic bursts (aes_lock).
// Optional macro AES_STARVE_GUARD_EN: after STARVE_MAX waiting cycles AES wins one slot.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   disp_req/disp_addr/disp_gnt      display read request, address, combinational grant
//   disp_rvalid/disp_rdata           display read return
//   aes_req/aes_we/aes_lock/aes_addr/aes_wdata/aes_gnt  AES request side and grant
//   aes_rvalid/aes_rdata             AES read return
//   addr_err                         pulse one cycle after a granted out-of-range access
//   mem_en/mem_we/mem_addr/mem_wdata registered BRAM controls; mem_rdata BRAM read data
module vga_img_mem_arbiter #(
    parameter int IMG_PIXELS = vga_img_pkg::IMG_W * vga_img_pkg::IMG_H,
    parameter int RD_LAT     = 1,
    parameter int BURST_MAX  = 16
`ifdef AES_STARVE_GUARD_EN
    , parameter int STARVE_MAX = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        disp_req,
    input  logic [14:0] disp_addr,
    output logic        disp_gnt,
    output logic        disp_rvalid,
    output logic [7:0]  disp_rdata,
    input  logic        aes_req,
    input  logic        aes_we,
    input  logic        aes_lock,
    input  logic [14:0] aes_addr,
    input  logic [7:0]  aes_wdata,
    output logic        aes_gnt,
    output logic        aes_rvalid,
    output logic [7:0]  aes_rdata,
    output logic        addr_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);
    import vga_img_pkg::*;

    localparam int          BURST_W   = $clog2(BURST_MAX + 1);
    localparam logic [31:0] PIX_LIMIT = 32'(IMG_PIXELS);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               aes_prio, gnt_any, acc_oob;
    logic [14:0]        acc_addr;
    logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d, addr_err_q, addr_err_d;
    logic [14:0]        mem_addr_q, mem_addr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;

`ifdef AES_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (aes_gnt) begin
            starve_d = '0;
        end else if (aes_req && (starve_q != STARVE_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end
`endif

    always_comb begin
        // AES outranks display inside a held lock, or once it has starved long enough.
        aes_prio = (state_q == AES_LOCK) && aes_lock;
`ifdef AES_STARVE_GUARD_EN
        if (starve_q == STARVE_W'(STARVE_MAX)) aes_prio = 1'b1;
`endif
        aes_gnt  = !rst && aes_req && (aes_prio || !disp_req);
        disp_gnt = !rst && disp_req && !aes_gnt;
        gnt_any  = aes_gnt || disp_gnt;
        acc_addr = aes_gnt ? aes_addr : disp_addr;
        acc_oob  = {17'd0, acc_addr} >= PIX_LIMIT;

        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            ARB: begin
                if (aes_gnt && aes_lock) begin
                    state_d = AES_LOCK;
                    burst_d = BURST_W'(1);
                end
            end
            AES_LOCK: begin
                if (!aes_lock) begin
                    state_d = ARB;
                    burst_d = '0;
                end else if (aes_gnt) begin
                    // The burst-ending grant hands the next slot back to ARB, where display wins.
                    if (burst_q == BURST_W'(BURST_MAX - 1)) begin
                        state_d = ARB;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ARB;
                burst_d = '0;
            end
        endcase

        mem_en_d    = gnt_any && !acc_oob;
        mem_we_d    = aes_gnt && aes_we && !acc_oob;
        mem_addr_d  = gnt_any ? acc_addr : mem_addr_q;
        mem_wdata_d = (aes_gnt && aes_we) ? aes_wdata : mem_wdata_q;
        addr_err_d  = gnt_any && acc_oob;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            burst_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 15'd0;
            mem_wdata_q <= 8'd0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign addr_err  = addr_err_q;

    // Writes produce no return, so only granted reads push a valid tag.
    img_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (gnt_any && !(aes_gnt && aes_we)),
        .in_aes      (aes_gnt),
        .in_oob      (acc_oob),
        .mem_rdata   (mem_rdata),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .aes_rvalid  (aes_rvalid),
        .aes_rdata   (aes_rdata)
    );
endmodule
